control_barrido_rtc: RTL and testbench
======================================

CONTROL_BARRIDO_RTC -- requirements
Module: control_barrido_rtc

Interface
REQ-001 Parameter TIMEOUT, default 255; maximum number of REQ cycles without rtc_ack before a sweep is aborted.
REQ-002 clk  input  1  single clock; all sequential logic SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  sweep request, sampled in IDLE only.
REQ-005 modo  input  1  sweep direction: 0 = read RTC into local regs, 1 = write local regs to RTC; latched when start is accepted.
REQ-006 rtc_req  output  1  RTC transaction request.
REQ-007 rtc_we  output  1  transaction type: 1 = write, 0 = read.
REQ-008 rtc_addr  output  8  RTC register address.
REQ-009 rtc_wdata  output  8  RTC write data.
REQ-010 rtc_ack  input  1  transaction complete; rtc_rdata is valid in the same cycle.
REQ-011 rtc_rdata  input  8  RTC read data.
REQ-012 mem_addr  output  4  local register index.
REQ-013 mem_we  output  1  local register write strobe.
REQ-014 mem_wdata  output  8  local register write data.
REQ-015 mem_rdata  input  8  local register read data, combinational from mem_addr.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  single-cycle end-of-sweep pulse.
REQ-018 error  output  1  sticky timeout flag.

Function
REQ-019 Fixed sweep order, index 0..9 -> rtc_addr 8'h21,22,23,24,25,26,27,41,42,43.
REQ-020 FSM states: IDLE, REQ, STORE, NEXT, DONE.
REQ-021 IDLE with start=1: latch modo, set idx=0, clear error, clear timeout counter -> REQ.
REQ-022 REQ: rtc_req=1, rtc_addr=table(idx), rtc_we=modo, rtc_wdata=mem_rdata (valid when modo=1, otherwise 8'h00); rtc_req stays high until rtc_ack.
REQ-023 REQ with rtc_ack=1: if modo=0, capture rtc_rdata and go to STORE; if modo=1, go to NEXT.
REQ-024 STORE: mem_we=1 for exactly one cycle, mem_wdata=captured data -> NEXT.
REQ-025 NEXT: if idx==9 -> DONE; else idx+1 and clear timeout counter -> REQ.
REQ-026 DONE: done=1 for one cycle -> IDLE.
REQ-027 mem_addr=idx in REQ, STORE and NEXT; mem_addr=4'b1111 in IDLE and DONE.
REQ-028 rtc_addr=8'h00 and rtc_req=0 outside REQ; mem_we=0 outside STORE.
REQ-029 The timeout counter SHALL increment on each REQ cycle without rtc_ack.
REQ-030 When the timeout counter reaches TIMEOUT: set error=1, write nothing to the local regs, go to DONE.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 If rtc_ack is high outside REQ, it SHALL be ignored.
REQ-033 Latency with rtc_ack high in the first REQ cycle: start accepted at edge 0 -> first REQ in cycle 1; read sweep asserts done in cycle 31; write sweep asserts done in cycle 21.
REQ-034 idx SHALL be 4 bits wide and SHALL never exceed 9.

Reset
REQ-035 reset=0 SHALL force immediately, from any state including mid-transaction: state=IDLE, idx=0, counter=0, captured data=0, rtc_req=0, rtc_we=0, rtc_addr=8'h00, rtc_wdata=8'h00, mem_we=0, mem_addr=4'b1111, mem_wdata=8'h00, busy=0, done=0, error=0.
REQ-036 After reset release, the FSM SHALL stay in IDLE until start=1.

Structure
REQ-037 The FSM state encoding, the sweep length 10 and the default TIMEOUT SHALL live in a shared package.
REQ-038 The index-to-RTC-address table SHALL be one combinational sub-module, tabla_direc_rtc (input 4-bit idx, output 8-bit address; 8'h00 for idx > 9).

Verification
REQ-039 Read sweep, modo=0, ack-in-same-cycle model with rdata = 8'h10+idx -> mem written at indices 0..9 with 8'h10..8'h19; done in cycle 31; error=0.
REQ-040 Write sweep, modo=1, mem_rdata = 8'hA0+mem_addr -> RTC sees writes 8'h21<-A0 ... 8'h43<-A9 in order; mem_we never high; done in cycle 21.
REQ-041 Ack delayed 3 cycles per register -> rtc_req held 4 cycles per register; rtc_addr stable while rtc_req is high.
REQ-042 TIMEOUT=8, ack never asserted -> error=1 after 8 REQ cycles; done pulses; no mem_we; the next start clears error.
REQ-043 reset=0 asserted while in STORE at idx=4 -> all outputs at reset values in the same cycle; a fresh start begins at 8'h21.
REQ-044 start pulsed while busy, plus a spurious rtc_ack in IDLE -> no effect on the sequence, no extra done pulse.

Source files
------------

// File: rtl/control_barrido_rtc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : control_barrido_rtc_pkg
//  Purpose : Shared definitions for the RTC sweep controller: FSM state
//            encoding, sweep length and default transaction timeout.
//  Ports   : none (package)
//  Rev     : 1.0 - initial release
// ============================================================================
package control_barrido_rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_STORE = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Number of RTC registers visited by one sweep
    localparam int         c_SWEEP_LEN       = 10;
    localparam logic [3:0] c_IDX_LAST        = 4'(c_SWEEP_LEN - 1);

    // Default number of unanswered REQ cycles before a sweep is aborted
    localparam int         c_TIMEOUT_DEFAULT = 255;

    // Local register index presented while no sweep slot is active
    localparam logic [3:0] c_MEM_ADDR_IDLE   = 4'hF;

endpackage : control_barrido_rtc_pkg
`default_nettype wire

// File: rtl/control_barrido_rtc_tabla_direc.sv
`default_nettype none
// ============================================================================
//  Module  : tabla_direc_rtc
//  Purpose : Combinational map from sweep index to RTC register address.
//            Indices 0..6 cover the time/date block (8'h21..8'h27), 7..9 the
//            control block (8'h41..8'h43); anything else yields 8'h00.
//  Ports   : idx  [3:0] in  - sweep index
//            addr [7:0] out - RTC register address
//  Rev     : 1.0 - initial release
// ============================================================================
module tabla_direc_rtc (
    input  logic [3:0] idx,
    output logic [7:0] addr
);

    always_comb begin
        addr = 8'h00;
        case (idx)
            4'd0:    addr = 8'h21;
            4'd1:    addr = 8'h22;
            4'd2:    addr = 8'h23;
            4'd3:    addr = 8'h24;
            4'd4:    addr = 8'h25;
            4'd5:    addr = 8'h26;
            4'd6:    addr = 8'h27;
            4'd7:    addr = 8'h41;
            4'd8:    addr = 8'h42;
            4'd9:    addr = 8'h43;
            default: addr = 8'h00;
        endcase
    end

endmodule : tabla_direc_rtc
`default_nettype wire

// File: rtl/control_barrido_rtc.sv
`default_nettype none
// ============================================================================
//  Module  : control_barrido_rtc
//  Purpose : Sweeps a fixed list of 10 RTC registers, either reading them
//            into a local register file (modo=0) or writing the local
//            registers out to the RTC (modo=1). Each RTC transaction waits
//            for rtc_ack, bounded by TIMEOUT cycles; a timeout aborts the
//            sweep and raises a sticky error flag.
//  Ports   : clk, reset (async, active low)
//            start, modo            - sweep request / direction
//            rtc_req/we/addr/wdata  - RTC transaction request
//            rtc_ack, rtc_rdata     - RTC completion and read data
//            mem_addr/we/wdata      - local register file write side
//            mem_rdata              - local register file read data (comb.)
//            busy, done, error      - status
//  Rev     : 1.0 - initial release
// ============================================================================
module control_barrido_rtc
    import control_barrido_rtc_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       modo,
    output logic       rtc_req,
    output logic       rtc_we,
    output logic [7:0] rtc_addr,
    output logic [7:0] rtc_wdata,
    input  logic       rtc_ack,
    input  logic [7:0] rtc_rdata,
    output logic [3:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int               CNT_W      = $clog2(TIMEOUT + 1);
    // An unanswered REQ cycle with the counter here brings it to TIMEOUT
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state,  w_state_nxt;
    logic [3:0]       r_idx,    w_idx_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [7:0]       r_data,   w_data_nxt;
    logic             r_modo,   w_modo_nxt;
    logic             r_error,  w_error_nxt;
    logic [7:0]       w_tab_addr;

    tabla_direc_rtc u_tabla (
        .idx  (r_idx),
        .addr (w_tab_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= '0;
            r_data  <= 8'h00;
            r_modo  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_modo  <= w_modo_nxt;
            r_error <= w_error_nxt;
        end
    end

    // Outputs decode from the registered state only, so an asynchronous
    // reset drives every output to its idle value without waiting for clk.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_modo_nxt  = r_modo;
        w_error_nxt = r_error;

        rtc_req     = 1'b0;
        rtc_we      = 1'b0;
        rtc_addr    = 8'h00;
        rtc_wdata   = 8'h00;
        mem_addr    = c_MEM_ADDR_IDLE;
        mem_we      = 1'b0;
        mem_wdata   = 8'h00;
        busy        = 1'b1;
        done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_modo_nxt  = modo;
                    w_idx_nxt   = 4'd0;
                    w_error_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_REQ;
                end
            end

            ST_REQ: begin
                rtc_req   = 1'b1;
                rtc_we    = r_modo;
                rtc_addr  = w_tab_addr;
                rtc_wdata = r_modo ? mem_rdata : 8'h00;
                mem_addr  = r_idx;
                if (rtc_ack) begin
                    if (r_modo) begin
                        w_state_nxt = ST_NEXT;
                    end else begin
                        w_data_nxt  = rtc_rdata;
                        w_state_nxt = ST_STORE;
                    end
                end else if (r_cnt == c_CNT_LAST) begin
                    // Abort without touching the local registers
                    w_error_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_STORE: begin
                mem_addr    = r_idx;
                mem_we      = 1'b1;
                mem_wdata   = r_data;
                w_state_nxt = ST_NEXT;
            end

            ST_NEXT: begin
                mem_addr = r_idx;
                if (r_idx == c_IDX_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt   = r_idx + 4'd1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_REQ;
                end
            end

            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign error = r_error;

endmodule : control_barrido_rtc
`default_nettype wire

// File: tb/tb_control_barrido_rtc.sv
`default_nettype none
// ============================================================================
//  Module  : tb_control_barrido_rtc
//  Purpose : Scoreboard bench for control_barrido_rtc. Stimulus pushes the
//            expected RTC transactions, local register writes and done
//            pulses into queues; a negedge monitor pops and compares them
//            as the DUT produces them. An RTC model answers requests after
//            a programmable delay.
//  Rev     : 1.0 - initial release
// ============================================================================
module tb_control_barrido_rtc;

    localparam int TB_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       modo;
    logic       rtc_req;
    logic       rtc_we;
    logic [7:0] rtc_addr;
    logic [7:0] rtc_wdata;
    logic       rtc_ack;
    logic [7:0] rtc_rdata;
    logic [3:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic       error;

    control_barrido_rtc #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .modo      (modo),
        .rtc_req   (rtc_req),
        .rtc_we    (rtc_we),
        .rtc_addr  (rtc_addr),
        .rtc_wdata (rtc_wdata),
        .rtc_ack   (rtc_ack),
        .rtc_rdata (rtc_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } rtc_txn_t;

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         t0        = 0;
    int         wait_cnt  = 0;
    int         ack_delay = 0;
    bit         ack_en    = 1'b1;
    bit         spur_ack  = 1'b0;

    rtc_txn_t   exp_rtc[$];
    logic [11:0] exp_mem[$];
    int         exp_lat[$];
    bit         exp_err[$];

    logic [7:0] c_addrs [10];
    logic [33:0] outs;
    localparam logic [33:0] c_RST_OUTS =
        {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'hF, 8'h00, 3'b000};

    assign outs = {rtc_req, rtc_we, rtc_addr, rtc_wdata, mem_we, mem_addr,
                   mem_wdata, busy, done, error};

    // RTC and local register file models
    assign rtc_ack   = (ack_en && rtc_req && (wait_cnt >= ack_delay)) || spur_ack;
    assign rtc_rdata = 8'h10 + {4'h0, mem_addr};
    assign mem_rdata = 8'hA0 + {4'h0, mem_addr};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rtc_req && !rtc_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_sweep(input bit m);
        for (int k = 0; k < 10; k++) begin
            rtc_txn_t t;
            t.we    = m;
            t.addr  = c_addrs[k];
            t.wdata = m ? (8'hA0 + 8'(k)) : 8'h00;
            exp_rtc.push_back(t);
            if (!m) exp_mem.push_back({4'(k), 8'h10 + 8'(k)});
        end
    endtask

    task automatic push_done(input bit e, input int lat);
        exp_err.push_back(e);
        exp_lat.push_back(lat);
    endtask

    task automatic do_start(input bit m);
        @(negedge clk);
        modo  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
        end
        #1;
        check("rtc_queue_drained", 64'(exp_rtc.size()), 64'd0);
        check("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
        exp_rtc.delete();
        exp_mem.delete();
    endtask

    // Scoreboard monitor
    initial begin : mon
        int hold = 0;
        logic [7:0] prev_addr = 8'h00;
        forever begin
            @(negedge clk);
            if (rtc_req) begin
                hold++;
                if (hold > 1) check("rtc_addr_stable", 64'(rtc_addr), 64'(prev_addr));
                prev_addr = rtc_addr;
                if (rtc_ack) begin
                    rtc_txn_t cur;
                    cur = {rtc_we, rtc_addr, rtc_wdata};
                    check("rtc_req_hold", 64'(hold), 64'(ack_delay + 1));
                    hold = 0;
                    if (exp_rtc.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rtc_txn: got %0h, expected none", cur);
                    end else begin
                        check("rtc_txn", 64'(cur), 64'(exp_rtc.pop_front()));
                    end
                end
            end else begin
                hold = 0;
            end

            if (mem_we) begin
                if (exp_mem.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mem_write: got %0h, expected none", {mem_addr, mem_wdata});
                end else begin
                    check("mem_write", 64'({mem_addr, mem_wdata}), 64'(exp_mem.pop_front()));
                end
            end

            if (done) begin
                if (exp_lat.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_pulse: got unexpected done at cycle %0d, expected none",
                             cyc - t0 + 1);
                end else begin
                    check("done_error", 64'(error), 64'(exp_err.pop_front()));
                    check("done_cycle", 64'(cyc - t0 + 1), 64'(exp_lat.pop_front()));
                end
            end
        end
    end

    initial begin : stim
        bit hit;
        c_addrs = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                    8'h41, 8'h42, 8'h43};
        reset = 1'b0;
        start = 1'b0;
        modo  = 1'b0;

        // Reset values, then idle after release
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(outs), 64'(c_RST_OUTS));
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_release", 64'(outs), 64'(c_RST_OUTS));

        // Read sweep, ack in first REQ cycle
        ack_delay = 0;
        push_sweep(1'b0);
        push_done(1'b0, 31);
        do_start(1'b0);
        wait_done(100);

        // Write sweep
        push_sweep(1'b1);
        push_done(1'b0, 21);
        do_start(1'b1);
        wait_done(100);

        // Read sweep with ack delayed 3 cycles: 6 cycles per register
        ack_delay = 3;
        push_sweep(1'b0);
        push_done(1'b0, 61);
        do_start(1'b0);
        wait_done(200);

        // Timeout: ack never comes
        ack_en    = 1'b0;
        ack_delay = 0;
        push_done(1'b1, TB_TIMEOUT + 1);
        do_start(1'b0);
        wait_done(100);
        @(negedge clk);
        check("error_sticky", 64'(error), 64'd1);
        check("idle_after_abort", 64'(busy), 64'd0);

        // Next start clears error
        ack_en = 1'b1;
        push_sweep(1'b1);
        push_done(1'b0, 21);
        do_start(1'b1);
        check("error_cleared", 64'(error), 64'd0);
        wait_done(100);

        // Reset while in STORE at idx=4
        for (int k = 0; k < 5; k++) begin
            rtc_txn_t t;
            t.we    = 1'b0;
            t.addr  = c_addrs[k];
            t.wdata = 8'h00;
            exp_rtc.push_back(t);
            exp_mem.push_back({4'(k), 8'h10 + 8'(k)});
        end
        do_start(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_we && mem_addr == 4'd4) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_store_idx4", 64'(hit), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("reset_mid_store", 64'(outs), 64'(c_RST_OUTS));
        check("rtc_queue_after_reset", 64'(exp_rtc.size()), 64'd0);
        check("mem_queue_after_reset", 64'(exp_mem.size()), 64'd0);
        exp_rtc.delete();
        exp_mem.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_mid_reset", 64'(outs), 64'(c_RST_OUTS));
        push_sweep(1'b0);
        push_done(1'b0, 31);
        do_start(1'b0);
        wait_done(100);

        // Spurious ack in IDLE, then start pulses while busy
        spur_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("spurious_ack_idle", 64'(outs), 64'(c_RST_OUTS));
        end
        @(negedge clk);
        spur_ack = 1'b0;
        push_sweep(1'b1);
        push_done(1'b0, 21);
        do_start(1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        modo  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        repeat (5) @(negedge clk);
        check("idle_after_busy_starts", 64'(busy), 64'd0);
        check("done_queue_drained", 64'(exp_lat.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule : tb_control_barrido_rtc
`default_nettype wire
